// File: rtl/apb_reg_pkg.sv
// Shared definitions for the APB register slave: register offsets,
// reset values, FSM state encoding and decode helpers.
package apb_reg_pkg;

    localparam logic [7:0] CTRL_OFF     = 8'h00;
    localparam logic [7:0] DATA_OFF     = 8'h04;
    localparam logic [7:0] STATUS_OFF   = 8'h08;
    localparam logic [7:0] INT_STAT_OFF = 8'h0C;
    localparam logic [7:0] INT_EN_OFF   = 8'h10;
    localparam logic [7:0] ID_OFF       = 8'h14;

    localparam logic [31:0] CTRL_RST     = 32'h0;
    localparam logic [31:0] DATA_RST     = 32'h0;
    localparam logic [15:0] STATUS_RST   = 16'h0;
    localparam logic [7:0]  INT_STAT_RST = 8'h0;
    localparam logic [7:0]  INT_EN_RST   = 8'h0;

    localparam int IRQ_EN_BIT = 1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_e;

    function automatic logic is_ro(input logic [7:0] off);
        return (off == STATUS_OFF) || (off == ID_OFF);
    endfunction

    function automatic logic is_mapped(input logic [7:0] off);
        return (off == CTRL_OFF) || (off == DATA_OFF) || (off == STATUS_OFF) ||
               (off == INT_STAT_OFF) || (off == INT_EN_OFF) || (off == ID_OFF);
    endfunction

endpackage

// File: rtl/apb_reg_fsm.sv
// APB3 handshake sequencer: tracks setup/access phases and counts down
// the access-phase wait states before raising PREADY.
//
//   state  | meaning
//   IDLE   | no transfer in flight; waiting for a setup phase
//   ACCESS | access phase; wait counter runs down to terminal count 0
module apb_reg_fsm
    import apb_reg_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic PCLK,
    input  logic PRESET,
    input  logic psel,
    input  logic penable,
    input  logic pwrite,
    output logic pready,
    output logic complete,
    output logic write_strobe
);

    apb_state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (psel && !penable) begin
                    state_d = ACCESS;
                    cnt_d   = 4'(WAIT_STATES);
                end
            end
            ACCESS: begin
                // A dropped strobe abandons the transfer without touching the counter.
                if (!psel || !penable) begin
                    state_d = IDLE;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pready       = (state_q == ACCESS) && (cnt_q == 4'd0);
        complete     = pready && psel && penable;
        write_strobe = complete && pwrite;
    end

endmodule

// File: rtl/apb_reg_slave.sv
// APB3 register slave: address decode, register file with W1C interrupt
// status, write counter and registered interrupt output.
module apb_reg_slave
    import apb_reg_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    input  logic [7:0]  hw_event,
    output logic [31:0] ctrl_o,
    output logic        irq_o
);

    logic        pready;
    logic        complete;
    logic        write_strobe;
    logic [7:0]  offset;
    logic        error;
    logic        wr_en;
    logic [7:0]  w1c_mask;
    logic [31:0] rdata;

    logic [31:0] ctrl_q, ctrl_d;
    logic [31:0] data_q, data_d;
    logic [15:0] status_q, status_d;
    logic [7:0]  int_stat_q, int_stat_d;
    logic [7:0]  int_en_q, int_en_d;
    logic        irq_q, irq_d;

    apb_reg_fsm #(.WAIT_STATES(WAIT_STATES)) u_fsm (
        .PCLK         (PCLK),
        .PRESET       (PRESET),
        .psel         (PSEL),
        .penable      (PENABLE),
        .pwrite       (PWRITE),
        .pready       (pready),
        .complete     (complete),
        .write_strobe (write_strobe)
    );

    always_comb begin
        offset = PADDR[7:0];
        error  = (PADDR[31:8] != BASE_ADDR[31:8]) || (PADDR[1:0] != 2'b00) ||
                 !is_mapped(offset) || (PWRITE && is_ro(offset));
        wr_en  = write_strobe && !error;
    end

    always_comb begin
        ctrl_d   = ctrl_q;
        data_d   = data_q;
        status_d = status_q;
        int_en_d = int_en_q;
        w1c_mask = 8'h00;
        if (wr_en) begin
            status_d = status_q + 16'd1;
            case (offset)
                CTRL_OFF:     ctrl_d   = PWDATA;
                DATA_OFF:     data_d   = PWDATA;
                INT_STAT_OFF: w1c_mask = PWDATA[7:0];
                INT_EN_OFF:   int_en_d = PWDATA[7:0];
                default:      ;
            endcase
        end
        // Hardware events are OR'd in after the clear so a coincident set wins.
        int_stat_d = (int_stat_q & ~w1c_mask) | hw_event;
        irq_d      = ctrl_q[IRQ_EN_BIT] & (|(int_stat_q & int_en_q));
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            ctrl_q     <= CTRL_RST;
            data_q     <= DATA_RST;
            status_q   <= STATUS_RST;
            int_stat_q <= INT_STAT_RST;
            int_en_q   <= INT_EN_RST;
            irq_q      <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            data_q     <= data_d;
            status_q   <= status_d;
            int_stat_q <= int_stat_d;
            int_en_q   <= int_en_d;
            irq_q      <= irq_d;
        end
    end

    always_comb begin
        case (offset)
            CTRL_OFF:     rdata = ctrl_q;
            DATA_OFF:     rdata = data_q;
            STATUS_OFF:   rdata = {16'h0, status_q};
            INT_STAT_OFF: rdata = {24'h0, int_stat_q};
            INT_EN_OFF:   rdata = {24'h0, int_en_q};
            ID_OFF:       rdata = ID_VALUE;
            default:      rdata = 32'h0;
        endcase
        PREADY  = pready;
        PRDATA  = (pready && !PWRITE && !error) ? rdata : 32'h0;
        PSLVERR = pready && error;
        ctrl_o  = ctrl_q;
        irq_o   = irq_q;
    end

endmodule

// File: tb/tb_apb_reg_slave.sv
// Scoreboard bench for apb_reg_slave: three instances with 0, 2 and 3 wait
// states share one APB bus, each selected by its own PSEL.
module tb_apb_reg_slave;

    localparam logic [31:0] BASE = 32'h4000_1000;
    localparam logic [31:0] ID   = 32'hA5B0_0001;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    logic        pclk = 1'b0;
    logic        preset;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [7:0]  hw_event;
    int          sel;
    bit          mon_en;

    logic [31:0] prdata  [3];
    logic        pready  [3];
    logic        pslverr [3];
    logic [31:0] ctrl_o  [3];
    logic        irq_o   [3];

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic int ws_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
    endfunction

    always #5 pclk = ~pclk;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        apb_reg_slave #(
            .WAIT_STATES(ws_of(k)),
            .BASE_ADDR  (BASE),
            .ID_VALUE   (ID)
        ) u_dut (
            .PCLK     (pclk),
            .PRESET   (preset),
            .PSEL     (psel && (sel == k)),
            .PENABLE  (penable),
            .PWRITE   (pwrite),
            .PADDR    (paddr),
            .PWDATA   (pwdata),
            .PRDATA   (prdata[k]),
            .PREADY   (pready[k]),
            .PSLVERR  (pslverr[k]),
            .hw_event (hw_event),
            .ctrl_o   (ctrl_o[k]),
            .irq_o    (irq_o[k])
        );
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    // Monitor: pops one expectation each time the selected slave completes.
    initial begin
        int   acc;
        exp_t e;
        acc = 0;
        forever begin
            @(negedge pclk);
            if (mon_en) begin
                if (psel && penable) begin
                    acc++;
                    if (pready[sel]) begin
                        check("exp_queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            check("prdata", prdata[sel], e.rdata);
                            check("pslverr", 32'(pslverr[sel]), 32'(e.err));
                            check("latency", 32'(acc), 32'(e.lat));
                        end
                        acc = 0;
                    end
                end else begin
                    acc = 0;
                    check("idle_pready", 32'(pready[sel]), 32'd0);
                end
            end
        end
    end

    task automatic apb_xfer(input int s, input bit wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] exp_rd,
                            input bit exp_err, input bit chk_hold,
                            input logic [31:0] hold_val, input bit rst_done);
        bit done;
        exp_q.push_back('{exp_rd, exp_err, ws_of(s) + 1});
        @(posedge pclk); #1;
        sel = s; psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
        @(posedge pclk); #1;
        penable = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge pclk);
            if (chk_hold) check("ctrl_hold", ctrl_o[s], hold_val);
            done = pready[s];
            if (done && rst_done) preset = 1'b1;
            @(posedge pclk); #1;
        end
        preset = 1'b0; psel = 1'b0; penable = 1'b0;
        check("xfer_done", 32'(done), 32'd1);
        if (!done && exp_q.size() != 0) void'(exp_q.pop_front());
    endtask

    task automatic wr(input int s, input logic [31:0] off, input logic [31:0] d, input bit err);
        apb_xfer(s, 1'b1, BASE + off, d, 32'h0, err, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic rd(input int s, input logic [31:0] off, input logic [31:0] exp, input bit err);
        apb_xfer(s, 1'b0, BASE + off, 32'h0, exp, err, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit fired;
        preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 32'h0; pwdata = 32'h0; hw_event = 8'h0; sel = 0; mon_en = 1'b0;
        repeat (2) @(posedge pclk);
        #1 preset = 1'b0;
        mon_en = 1'b1;

        // Reset state and idle behaviour
        @(negedge pclk);
        check("rst_pready", 32'(pready[0]), 32'd0);
        check("rst_prdata", prdata[0], 32'h0);
        check("rst_pslverr", 32'(pslverr[0]), 32'd0);
        check("rst_ctrl_o", ctrl_o[0], 32'h0);
        check("rst_irq_o", 32'(irq_o[0]), 32'd0);
        rd(0, 32'h00, 32'h0, 1'b0);
        rd(0, 32'h14, ID, 1'b0);

        // Basic read/write, zero wait states
        wr(0, 32'h04, 32'hDEAD_BEEF, 1'b0);
        rd(0, 32'h04, 32'hDEAD_BEEF, 1'b0);
        rd(0, 32'h08, 32'h0000_0001, 1'b0);
        wr(0, 32'h00, 32'h0000_0002, 1'b0);
        check("ctrl_o_after_write", ctrl_o[0], 32'h0000_0002);

        // Interrupt set, irq latency, W1C clear, set-beats-clear
        wr(0, 32'h10, 32'h0000_0008, 1'b0);
        hw_event = 8'h08;
        @(posedge pclk); #1 hw_event = 8'h00;
        @(negedge pclk);
        check("irq_lag", 32'(irq_o[0]), 32'd0);
        @(negedge pclk);
        check("irq_set", 32'(irq_o[0]), 32'd1);
        rd(0, 32'h0C, 32'h0000_0008, 1'b0);
        rd(0, 32'h10, 32'h0000_0008, 1'b0);
        wr(0, 32'h0C, 32'h0000_0008, 1'b0);
        @(negedge pclk);
        check("irq_clear_lag", 32'(irq_o[0]), 32'd1);
        @(negedge pclk);
        check("irq_cleared", 32'(irq_o[0]), 32'd0);
        rd(0, 32'h0C, 32'h0, 1'b0);
        fired = 1'b0;
        fork
            wr(0, 32'h0C, 32'h0000_0008, 1'b0);
            for (int i = 0; i < 40 && !fired; i++) begin
                @(negedge pclk);
                if (psel && penable && pready[0]) begin
                    hw_event = 8'h08;
                    fired = 1'b1;
                    @(posedge pclk); #1 hw_event = 8'h00;
                end
            end
        join
        rd(0, 32'h0C, 32'h0000_0008, 1'b0);

        // Error responses
        wr(0, 32'h08, 32'h0000_FFFF, 1'b1);
        rd(0, 32'h08, 32'h0000_0005, 1'b0);
        rd(0, 32'h40, 32'h0, 1'b1);
        wr(0, 32'h05, 32'h1111_1111, 1'b1);
        rd(0, 32'h100, 32'h0, 1'b1);
        wr(0, 32'h14, 32'h0, 1'b1);
        rd(0, 32'h08, 32'h0000_0005, 1'b0);
        rd(0, 32'h00, 32'h0000_0002, 1'b0);

        // Two wait states: CTRL must hold its old value until the completing edge
        wr(1, 32'h04, 32'h1234_5678, 1'b0);
        rd(1, 32'h04, 32'h1234_5678, 1'b0);
        apb_xfer(1, 1'b1, BASE + 32'h00, 32'h0000_0005, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0);
        check("ctrl_o_ws2", ctrl_o[1], 32'h0000_0005);

        // Three wait states: abort in the 2nd access cycle
        wr(2, 32'h04, 32'hCAFE_0001, 1'b0);
        @(posedge pclk); #1;
        sel = 2; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = BASE + 32'h04; pwdata = 32'h0000_0BAD;
        @(posedge pclk); #1 penable = 1'b1;
        @(posedge pclk); #1 penable = 1'b0;
        @(posedge pclk); #1 psel = 1'b0;
        rd(2, 32'h04, 32'hCAFE_0001, 1'b0);
        rd(2, 32'h08, 32'h0000_0001, 1'b0);
        wr(2, 32'h00, 32'h0000_0077, 1'b0);
        rd(2, 32'h00, 32'h0000_0077, 1'b0);

        // Reset landing on the completing edge: nothing commits
        apb_xfer(2, 1'b1, BASE + 32'h04, 32'h0000_0099, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        @(negedge pclk);
        check("pready_after_reset", 32'(pready[2]), 32'd0);
        check("ctrl_o_after_reset", ctrl_o[2], 32'h0);
        rd(2, 32'h00, 32'h0, 1'b0);
        rd(2, 32'h04, 32'h0, 1'b0);
        rd(2, 32'h08, 32'h0, 1'b0);

        check("exp_queue_drained", 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge pclk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/apb_reg_slave.md
Name: apb_reg_slave

Overview:
APB3 slave register block driven by the verification environment's APB driver; it is the DUT-side consumer of the PSEL/PENABLE/PWRITE/PADDR/PWDATA bus, and it returns PRDATA, PREADY and PSLVERR. It holds a small register map (control, data, status counter, W1C interrupt status, interrupt enable, ID) that the RAL model mirrors. Wait-state insertion and error responses are configurable so the bench can exercise the full APB handshake.

Parameters:
WAIT_STATES, 0, access-phase wait cycles before PREADY (legal range 0..15; 4-bit counter)
BASE_ADDR, 32'h0000_0000, decode base; window is 256 bytes and matches on PADDR[31:8]==BASE_ADDR[31:8]
ID_VALUE, 32'hA5B0_0001, constant returned by the ID register

Ports:
PCLK  in  1  clock; all logic on posedge
PRESET  in  1  synchronous, active-high reset
PSEL  in  1  slave select
PENABLE  in  1  access-phase strobe
PWRITE  in  1  1=write, 0=read
PADDR  in  32  byte address
PWDATA  in  32  write data
PRDATA  out  32  read data, valid when PREADY=1
PREADY  out  1  transfer-complete
PSLVERR  out  1  error response, valid when PREADY=1
hw_event  in  8  single-cycle event pulses that set INT_STAT bits
ctrl_o  out  32  current CTRL register value
irq_o  out  1  registered interrupt

Behaviour:
- Clock PCLK; reset PRESET is synchronous and active-high. Reset forces state to IDLE, wait counter to 0, and all registers to their reset values. Outputs during and after reset: PRDATA=0, PREADY=0, PSLVERR=0, ctrl_o=0, irq_o=0.
- Register map (offset = PADDR[7:0]):
  - 0x00 CTRL: RW, reset 0. bit1 = irq_en; the other bits are software-defined.
  - 0x04 DATA: RW, reset 0.
  - 0x08 STATUS: RO. [15:0] = count of successful writes, wraps 0xFFFF->0; [31:16] = 0.
  - 0x0C INT_STAT: [7:0] W1C, reset 0; [31:8] read 0.
  - 0x10 INT_EN: [7:0] RW, reset 0.
  - 0x14 ID: RO = ID_VALUE.
- FSM states:
  - IDLE: on an edge sampling PSEL=1 and PENABLE=0 (setup phase), go to ACCESS and load cnt=WAIT_STATES.
  - ACCESS, abort path: on an edge sampling PSEL=0 or PENABLE=0, go to IDLE with no commit and no counter change.
  - ACCESS, wait path: else if cnt!=0, decrement cnt.
  - ACCESS, complete path: else the transfer completes on this edge and the FSM goes to IDLE.
  - Back-to-back transfers: the next setup phase is sampled in IDLE the following cycle.
- Handshake outputs:
  - PREADY = (state==ACCESS && cnt==0), combinational from registered state.
  - Latency: PREADY is high in access cycle WAIT_STATES+1.
  - PRDATA = read mux of the decoded register when PREADY && !PWRITE && !error; otherwise 0.
  - PSLVERR = PREADY && error.
- Error conditions (any one sets error):
  - PADDR outside the decode window
  - PADDR[1:0]!=0
  - offset not in the map
  - write to STATUS or ID
- On error: no register update, STATUS is not incremented, PRDATA=0.
- Write commit: on the completing edge with PWRITE=1 and no error, update the target register and increment STATUS[15:0].
- INT_STAT per bit:
  - next = (cur & ~(w1c_mask)) | hw_event.
  - Set wins over a simultaneous W1C clear.
  - An event at edge N is visible in INT_STAT after edge N.
- irq_o register: irq_o <= CTRL[1] & |(INT_STAT & INT_EN[7:0]). irq_o lags INT_STAT by one cycle.
- Reads have no side effects; INT_STAT is not clear-on-read.
- Reset mid-transfer: the transfer is abandoned, nothing is committed, PREADY drops the cycle after the reset edge.

Decomposition:
- Package apb_reg_pkg holds:
  - offset localparams (CTRL_OFF..ID_OFF)
  - state enum {IDLE, ACCESS}
  - reset-value localparams
  - a function is_ro(offset)
- One sub-module, apb_reg_fsm:
  - Contains the IDLE/ACCESS FSM and the wait counter.
  - Outputs PREADY plus complete/write strobes.
  - The top level holds the decode, the registers and the read mux.

Test Plan:
1. Reset: assert PRESET 2 cycles, then read 0x00 -> PRDATA=0; read 0x14 -> PRDATA=0xA5B0_0001. PREADY stays 0 while idle.
2. Write 0x04=0xDEAD_BEEF, then read 0x04 -> 0xDEAD_BEEF, PSLVERR=0. Read 0x08 -> 0x0000_0001. Write 0x00=0x2 -> ctrl_o=0x0000_0002.
3. WAIT_STATES=2: write 0x04=0x1234_5678 -> PREADY high only in the 3rd access cycle. Register unchanged until that edge. Read returns 0x1234_5678.
4. Interrupt sequence:
   - Write INT_EN=0x08 and CTRL=0x2, pulse hw_event=0x08 -> INT_STAT=0x08; irq_o=1 one cycle later.
   - Write INT_STAT=0x08 -> INT_STAT=0x00, irq_o=0.
   - Repeat with hw_event[3] on the commit edge -> INT_STAT stays 0x08.
5. Errors:
   - Write 0x08=0xFFFF -> PSLVERR=1, STATUS unchanged.
   - Read 0x40 -> PRDATA=0, PSLVERR=1.
   - Write 0x05 -> PSLVERR=1.
   - Read with PADDR=BASE_ADDR+0x100 -> PSLVERR=1.
6. Abort/reset:
   - With WAIT_STATES=3, drop PENABLE in the 2nd access cycle -> no commit, FSM back to IDLE, next transfer completes normally.
   - Assert PRESET mid-access -> PREADY=0, CTRL/DATA/STATUS read 0.
